// File: rtl/alu64.sv
// 64-bit LEGv8-style ALU with a registered result, zero flag and out_valid.
// Optional registered N/C/V flags are built in when ALU_FLAGS_EN is defined.
module alu64 #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       ALUControl,
   input  logic             in_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             out_valid
`ifdef ALU_FLAGS_EN
   ,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             flags_valid
`endif
);

   localparam logic [4:0] OP_AND   = 5'b00000;
   localparam logic [4:0] OP_OR    = 5'b00001;
   localparam logic [4:0] OP_ADD   = 5'b00010;
   localparam logic [4:0] OP_XOR   = 5'b00011;
   localparam logic [4:0] OP_SUB   = 5'b00110;
   localparam logic [4:0] OP_PASSB = 5'b00111;
   localparam logic [4:0] OP_LSL   = 5'b01000;
   localparam logic [4:0] OP_LSR   = 5'b01001;
   localparam logic [4:0] OP_ASR   = 5'b01010;
   localparam logic [4:0] OP_SLT   = 5'b01011;
   localparam logic [4:0] OP_NOR   = 5'b01100;
   localparam logic [4:0] OP_SLTU  = 5'b01101;

   logic [WIDTH-1:0] op_res;
   logic [5:0]       shamt;
   logic [WIDTH-1:0] result_d, result_q;
   logic             zero_d, zero_q;
   logic             out_valid_d, out_valid_q;

   // Only the low six bits of b ever steer a shift.
   assign shamt = b[5:0];

   always_comb begin
      op_res = '0;
      case (ALUControl)
         OP_AND:   op_res = a & b;
         OP_OR:    op_res = a | b;
         OP_ADD:   op_res = a + b;
         OP_XOR:   op_res = a ^ b;
         OP_SUB:   op_res = a - b;
         OP_PASSB: op_res = b;
         OP_LSL:   op_res = a << shamt;
         OP_LSR:   op_res = a >> shamt;
         OP_ASR:   op_res = $signed(a) >>> shamt;
         OP_SLT:   op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_NOR:   op_res = ~(a | b);
         OP_SLTU:  op_res = {{(WIDTH-1){1'b0}}, (a < b)};
         default:  op_res = '0;
      endcase
   end

   always_comb begin
      result_d    = result_q;
      zero_d      = zero_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         result_d = op_res;
         zero_d   = (op_res == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q    <= '0;
         zero_q      <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign result    = result_q;
   assign zero      = zero_q;
   assign out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
   logic negative_d, negative_q;
   logic carry_d, carry_q;
   logic overflow_d, overflow_q;

   // Carry is an unsigned wrap for ADD and "no borrow" for SUB.
   always_comb begin
      negative_d = negative_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      if (in_valid) begin
         negative_d = op_res[WIDTH-1];
         carry_d    = 1'b0;
         overflow_d = 1'b0;
         if (ALUControl == OP_ADD) begin
            carry_d    = (op_res < a);
            overflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
         end else if (ALUControl == OP_SUB) begin
            carry_d    = (a >= b);
            overflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         negative_q <= 1'b0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         negative_q <= negative_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
      end
   end

   assign negative    = negative_q;
   assign carry       = carry_q;
   assign overflow    = overflow_q;
   assign flags_valid = out_valid_q;
`endif

endmodule

// File: tb/tb_alu64.sv
// Self-checking bench for alu64: directed scenarios plus randomized ops
// scored against a behavioural model built from the operation definitions.
module tb_alu64;

   logic        clk;
   logic        rst_n;
   logic [63:0] a;
   logic [63:0] b;
   logic [4:0]  ctl;
   logic        in_valid;
   logic [63:0] result;
   logic        zero;
   logic        out_valid;
`ifdef ALU_FLAGS_EN
   logic        negative, carry, overflow, flags_valid;
`endif

   int checks = 0;
   int errors = 0;

   alu64 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .ALUControl (ctl),
      .in_valid   (in_valid),
      .result     (result),
      .zero       (zero),
      .out_valid  (out_valid)
`ifdef ALU_FLAGS_EN
      ,
      .negative   (negative),
      .carry      (carry),
      .overflow   (overflow),
      .flags_valid(flags_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural reference: each op written from its arithmetic meaning.
   function automatic logic [63:0] ref_op(input logic [63:0] x, input logic [63:0] y,
                                          input logic [4:0] c);
      logic [63:0] msb;
      int s;
      msb = 64'h8000_0000_0000_0000;
      s = int'(y[5:0]);
      case (c)
         5'b00000: return x & y;
         5'b00001: return x | y;
         5'b00010: return x + y;
         5'b00011: return x ^ y;
         5'b00110: return x + (~y + 64'd1);
         5'b00111: return y;
         5'b01000: return x << s;
         5'b01001: return x >> s;
         5'b01010: return x[63] ? ~((~x) >> s) : (x >> s);
         5'b01011: return ((x ^ msb) < (y ^ msb)) ? 64'd1 : 64'd0;
         5'b01100: return ~(x | y);
         5'b01101: return (x < y) ? 64'd1 : 64'd0;
         default:  return 64'd0;
      endcase
   endfunction

`ifdef ALU_FLAGS_EN
   // Returns {carry, overflow} using 65-bit sign/zero-extended arithmetic.
   function automatic logic [1:0] ref_cv(input logic [63:0] x, input logic [63:0] y,
                                         input logic [4:0] c);
      logic [64:0] u, sg;
      if (c == 5'b00010) begin
         u  = {1'b0, x} + {1'b0, y};
         sg = {x[63], x} + {y[63], y};
         return {u[64], sg[64] != sg[63]};
      end else if (c == 5'b00110) begin
         sg = {x[63], x} - {y[63], y};
         return {(x >= y), sg[64] != sg[63]};
      end
      return 2'b00;
   endfunction
`endif

   // Drive one operation and step to just after the capturing edge.
   task automatic drive(input logic [63:0] x, input logic [63:0] y,
                        input logic [4:0] c, input logic v);
      a = x;
      b = y;
      ctl = c;
      in_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(64'd3, 64'd4, 5'b00010, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (result !== 64'd0 || zero !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: result=%h zero=%b out_valid=%b, want 0/1/0",
                  result, zero, out_valid);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if ({negative, carry, overflow, flags_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: nczv=%b want 0000",
                  {negative, carry, overflow, flags_valid});
      end
`endif
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_add_sweep();
      int bad;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 10; j++) begin
            drive(64'(i), 64'(j), 5'b00010, 1'b1);
            if (result !== 64'(i + j) || zero !== (i + j == 0) || out_valid !== 1'b1) begin
               bad++;
               $display("FAIL add_sweep %0d+%0d: result=%0d zero=%b, want %0d zero=%b",
                        i, j, result, zero, i + j, (i + j == 0));
            end
         end
      end
      checks++;
      if (bad != 0) errors++;
   endtask

   task automatic test_wrap_sub();
      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b00010, 1'b1);
      checks++;
      if (result !== 64'd0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL add_wrap: result=%h zero=%b, want 0 zero=1", result, zero);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (carry !== 1'b1) begin
         errors++;
         $display("FAIL add_wrap_carry: carry=%b want 1", carry);
      end
`endif
      drive(64'd5, 64'd7, 5'b00110, 1'b1);
      checks++;
      if (result !== 64'hFFFF_FFFF_FFFF_FFFE || zero !== 1'b0) begin
         errors++;
         $display("FAIL sub_5_7: result=%h zero=%b, want fffffffffffffffe zero=0", result, zero);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (negative !== 1'b1 || carry !== 1'b0) begin
         errors++;
         $display("FAIL sub_5_7_flags: n=%b c=%b want n=1 c=0", negative, carry);
      end
`endif
      drive(64'd0, 64'd1, 5'b00110, 1'b1);
      checks++;
      if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errors++;
         $display("FAIL sub_0_1: result=%h want ffffffffffffffff", result);
      end
   endtask

   task automatic test_logic_shift();
      logic [4:0]  codes [6];
      logic [63:0] want  [6];
      logic [63:0] ya    [6];
      logic [63:0] yb    [6];
      codes = '{5'b00000, 5'b00001, 5'b00011, 5'b01010, 5'b01000, 5'b01001};
      ya    = '{64'hF0F0, 64'hF0F0, 64'hF0F0, 64'h8000_0000_0000_0000,
                64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0001};
      yb    = '{64'h0FF0, 64'h0FF0, 64'h0FF0, 64'h41, 64'hFFFF_FFFF_FFFF_FFC0, 64'h3F};
      want  = '{64'h00F0, 64'hFFF0, 64'hFF00, 64'hC000_0000_0000_0000,
                64'h1234_5678_9ABC_DEF0, 64'h1};
      for (int i = 0; i < 6; i++) begin
         drive(ya[i], yb[i], codes[i], 1'b1);
         checks++;
         if (result !== want[i]) begin
            errors++;
            $display("FAIL logic_shift[%0d] op=%b: result=%h want %h", i, codes[i], result, want[i]);
         end
      end
   endtask

   task automatic test_compare();
      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b01011, 1'b1);
      checks++;
      if (result !== 64'd1 || zero !== 1'b0) begin
         errors++;
         $display("FAIL slt_neg: result=%h zero=%b want 1/0", result, zero);
      end
      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b01101, 1'b1);
      checks++;
      if (result !== 64'd0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL sltu: result=%h zero=%b want 0/1", result, zero);
      end
      drive(64'd9, 64'd9, 5'b00010, 1'b1);
      drive(64'd9, 64'd9, 5'b11111, 1'b1);
      checks++;
      if (result !== 64'd0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL undef_op: result=%h zero=%b want 0/1", result, zero);
      end
      drive(64'd1, 64'hABCD, 5'b00111, 1'b1);
      checks++;
      if (result !== 64'hABCD) begin
         errors++;
         $display("FAIL passb: result=%h want abcd", result);
      end
      drive(64'hF0, 64'h0F, 5'b01100, 1'b1);
      checks++;
      if (result !== 64'hFFFF_FFFF_FFFF_FF00) begin
         errors++;
         $display("FAIL nor: result=%h want ffffffffffffff00", result);
      end
   endtask

   task automatic test_valid();
      drive(64'd20, 64'd22, 5'b00010, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || result !== 64'd42) begin
         errors++;
         $display("FAIL valid_pulse: out_valid=%b result=%0d want 1/42", out_valid, result);
      end
      for (int k = 0; k < 3; k++) begin
         drive(64'($urandom), 64'($urandom), 5'b00001, 1'b0);
         checks++;
         if (out_valid !== 1'b0 || result !== 64'd42 || zero !== 1'b0) begin
            errors++;
            $display("FAIL valid_hold[%0d]: out_valid=%b result=%0d zero=%b want 0/42/0",
                     k, out_valid, result, zero);
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] exp_q[$];
      logic [63:0] held, x, y, e;
      logic [4:0]  c;
      logic        v;
      logic [4:0]  pool [14];
      int bad;
      pool = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00110, 5'b00111, 5'b01000,
               5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b10010, 5'b01110};
      bad = 0;
      held = result;
      for (int n = 0; n < 300; n++) begin
         x = {$urandom, $urandom};
         y = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) y = x;
         c = pool[$urandom_range(0, 13)];
         v = ($urandom_range(0, 4) != 0);
         if (v) held = ref_op(x, y, c);
         exp_q.push_back(held);
         drive(x, y, c, v);
         e = exp_q.pop_front();
         if (result !== e || zero !== (e == 64'd0) || out_valid !== v) begin
            bad++;
            $display("FAIL random[%0d] op=%b v=%b: result=%h zero=%b ov=%b want %h",
                     n, c, v, result, zero, out_valid, e);
         end
`ifdef ALU_FLAGS_EN
         if (v && ({carry, overflow} !== ref_cv(x, y, c) || negative !== e[63]
                   || flags_valid !== 1'b1)) begin
            bad++;
            $display("FAIL random_flags[%0d] op=%b: ncv=%b%b%b want %b%b",
                     n, c, negative, carry, overflow, e[63], ref_cv(x, y, c));
         end
`endif
      end
      checks++;
      if (bad != 0) errors++;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      ctl = '0;
      #12;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (result !== 64'd0 || zero !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_initial: result=%h zero=%b out_valid=%b", result, zero, out_valid);
      end
      test_reset();
      test_add_sweep();
      test_wrap_sub();
      test_logic_shift();
      test_compare();
      test_valid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu64.md
Name: alu64

Overview:
- 64-bit integer ALU for the single-cycle datapath (LEGv8-style control encoding).
- Computes one of a fixed set of arithmetic, logic and shift operations on operands a and b, selected by a 5-bit ALUControl code.
- Result and zero flag are registered: one clock of latency.
- Sits between the register-file/immediate mux and the write-back/branch logic.

Parameters:
- WIDTH, 64, operand and result width in bits; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ALUControl  input  5  operation select
- in_valid  input  1  operands and control are valid this cycle
- result  output  WIDTH  registered operation result
- zero  output  1  registered; 1 when result == 0
- out_valid  output  1  registered; result/zero correspond to an accepted operation

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-operation): result=0, zero=1, out_valid=0. Flags (if enabled) = 0. A pending operation is discarded.
- On each rising clk with rst_n high and in_valid=1:
  - result <= op(a, b)
  - zero <= (op(a, b) == 0)
  - out_valid <= 1
- On each rising clk with rst_n high and in_valid=0: out_valid <= 0; result and zero hold their previous values.
- Latency: exactly 1 cycle. Throughput: 1 operation per cycle. No backpressure.
- Op codes (binary):
  - 00000 AND
  - 00001 OR
  - 00010 ADD (a+b, carry out of bit WIDTH-1 discarded)
  - 00110 SUB (a-b, two's complement)
  - 00111 PASSB (result=b)
  - 01100 NOR
  - 00011 XOR
  - 01000 LSL (a << b[5:0])
  - 01001 LSR (logical a >> b[5:0])
  - 01010 ASR (arithmetic a >>> b[5:0])
  - 01011 SLT (signed a<b ? 1 : 0)
  - 01101 SLTU (unsigned a<b ? 1 : 0)
- Any other code: result=0, zero=1; no other side effect.
- Shift amount uses only b[5:0]; b[63:6] is ignored. Shift by 0 returns a.
- Wrap-around: ADD 0xFFFF_FFFF_FFFF_FFFF + 1 = 0 with zero=1. SUB 0 - 1 = all ones.
- ALUControl bits [4:0] are fully decoded. A 4-bit driver zero-extends into bit 4, so 4'b0010 selects ADD.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- When defined, adds four registered 1-bit outputs, updated alongside result and cleared on reset:
  - negative = result[WIDTH-1]
  - carry = carry out for ADD; NOT borrow for SUB; 0 for all other ops
  - overflow = signed overflow for ADD/SUB; 0 for all other ops
  - flags_valid = out_valid
- When undefined, these ports and their logic are absent. Other behaviour is unchanged.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> result=0, zero=1, out_valid=0 immediately, without waiting for a clock edge.
- ADD sweep: ALUControl=00010, a,b each over 0..9 (100 pairs), in_valid=1 -> next cycle result=a+b, zero=1 only for 0+0; 0 mismatches.
- Wrap/SUB: ADD all-ones + 1 -> result=0, zero=1 (carry=1 if ALU_FLAGS_EN). SUB 5-7 -> 0xFFFF_FFFF_FFFF_FFFE, zero=0 (negative=1).
- Logic and shifts:
  - a=0xF0F0, b=0x0FF0: AND -> 0x00F0, OR -> 0xFFF0, XOR -> 0xFF00.
  - ASR of 0x8000_0000_0000_0000 by b=0x41 (uses b[5:0]=1) -> 0xC000_0000_0000_0000.
- Compare: a=-1, b=1: SLT -> 1, SLTU -> 0. Undefined code 11111 -> result=0, zero=1.
- Valid handling: in_valid pulses high for one cycle, then low for 3 cycles -> out_valid high for exactly one cycle; result held afterward.
